// File: rtl/bsg_id_pool_multiport_with_reserve.sv
// ---------------------------------------------------------------------------
// bsg_id_pool_multiport_with_reserve
//
// Multi-port ID pool ("coatcheck"). It tracks which of els_p IDs are allocated.
// Each cycle it offers up to alloc_ports_p distinct free IDs, lowest index
// first, and accepts up to dealloc_ports_p returns. A caller-supplied reserve
// mask keeps selected IDs from being offered. It also keeps a registered count
// of allocated IDs for flow control.
//
// Ports
//   clk_i              clock
//   reset_i            synchronous reset, active-high
//   reserve_i          bit i = 1: ID i is never offered (applies the same cycle)
//   alloc_v_o          channel k has an ID on offer (prefix-contiguous)
//   alloc_id_o         ID offered on channel k, in slice k
//   alloc_yumi_i       channel k's offered ID is taken this cycle
//   dealloc_v_i        return valid for channel j
//   dealloc_id_i       ID returned on channel j, in slice j
//   allocated_count_o  registered popcount of the allocated vector
//   full_o             nothing offerable (== ~alloc_v_o[0])
// ---------------------------------------------------------------------------
module bsg_id_pool_multiport_with_reserve
  #(parameter int els_p           = 8  // set by the instantiating module
   ,parameter int alloc_ports_p   = 2
   ,parameter int dealloc_ports_p = 2
   ,localparam int id_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
   ,localparam int count_width_lp = $clog2(els_p + 1)
   )
  (input  logic                                     clk_i
  ,input  logic                                     reset_i
  ,input  logic [els_p-1:0]                         reserve_i
  ,output logic [alloc_ports_p-1:0]                 alloc_v_o
  ,output logic [alloc_ports_p*id_width_lp-1:0]     alloc_id_o
  ,input  logic [alloc_ports_p-1:0]                 alloc_yumi_i
  ,input  logic [dealloc_ports_p-1:0]               dealloc_v_i
  ,input  logic [dealloc_ports_p*id_width_lp-1:0]   dealloc_id_i
  ,output logic [count_width_lp-1:0]                allocated_count_o
  ,output logic                                     full_o
  );

  logic [els_p-1:0]          allocated_q, allocated_d;
  logic [count_width_lp-1:0] count_q, count_d;

  logic [els_p-1:0]                              free;
  logic [els_p-1:0]                              remaining;
  logic [alloc_ports_p-1:0]                      offer_v;
  logic [alloc_ports_p-1:0][id_width_lp-1:0]     offer_id;
  logic [dealloc_ports_p-1:0][id_width_lp-1:0]   dealloc_id;
  logic [els_p-1:0]                              alloc_set;
  logic [els_p-1:0]                              dealloc_clr;
  int                                            n_alloc;
  int                                            n_dealloc;

  assign dealloc_id = dealloc_id_i;

  // Free vector comes from registered state only. A returned ID therefore
  // becomes offerable one cycle after its return, and the offer never depends
  // on alloc_yumi_i.
  assign free = ~allocated_q & ~reserve_i;

  // Channel k takes the lowest set bit left after channels 0..k-1 removed
  // theirs, which gives the (k+1)-th lowest free ID.
  // NOTE: every variable written here gets a default first, so the tool infers
  // no latch. Combinational blocks use blocking '=' so later statements see
  // earlier updates.
  always_comb begin
    remaining = free;
    offer_v   = '0;
    offer_id  = '0;
    for (int k = 0; k < alloc_ports_p; k++) begin
      for (int i = els_p - 1; i >= 0; i--) begin
        if (remaining[i]) offer_id[k] = id_width_lp'(i);
      end
      offer_v[k] = |remaining;
      if (offer_v[k]) remaining[offer_id[k]] = 1'b0;
    end
  end

  assign alloc_v_o         = reset_i ? '0 : offer_v;
  assign alloc_id_o        = offer_id;
  assign full_o            = ~alloc_v_o[0];
  assign allocated_count_o = count_q;

  // Set and clear always target disjoint IDs. Accepted offers are free, and
  // returns must be allocated, so the OR-then-mask order is arbitrary.
  always_comb begin
    alloc_set   = '0;
    dealloc_clr = '0;
    n_alloc     = 0;
    n_dealloc   = 0;
    for (int k = 0; k < alloc_ports_p; k++) begin
      if (alloc_yumi_i[k] && alloc_v_o[k]) begin
        alloc_set[offer_id[k]] = 1'b1;
        n_alloc++;
      end
    end
    for (int j = 0; j < dealloc_ports_p; j++) begin
      if (dealloc_v_i[j]) begin
        dealloc_clr[dealloc_id[j]] = 1'b1;
        n_dealloc++;
      end
    end
    allocated_d = (allocated_q | alloc_set) & ~dealloc_clr;
    count_d     = count_width_lp'(int'(count_q) + n_alloc - n_dealloc);
    if (reset_i) begin
      allocated_d = '0;
      count_d     = '0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' only. Reset is already
  // folded into the _d terms, so this block is a plain register.
  always_ff @(posedge clk_i) begin
    allocated_q <= allocated_d;
    count_q     <= count_d;
  end

`ifndef SYNTHESIS
  // Protocol checks, sampled mid-cycle once inputs have settled.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      for (int j = 0; j < dealloc_ports_p; j++) begin
        if (dealloc_v_i[j]) begin
          assert (int'(dealloc_id[j]) < els_p)
            else $error("dealloc id %0d out of range", dealloc_id[j]);
          assert ((int'(dealloc_id[j]) >= els_p) || allocated_q[dealloc_id[j]])
            else $error("dealloc of unallocated id %0d", dealloc_id[j]);
          for (int m = j + 1; m < dealloc_ports_p; m++) begin
            assert (!(dealloc_v_i[m] && (dealloc_id[m] == dealloc_id[j])))
              else $error("duplicate dealloc id %0d", dealloc_id[j]);
          end
        end
      end
      for (int k = 0; k < alloc_ports_p; k++) begin
        assert (!alloc_yumi_i[k] || alloc_v_o[k])
          else $error("alloc_yumi_i[%0d] without alloc_v_o", k);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_id_pool_multiport_with_reserve.sv
// ---------------------------------------------------------------------------
// Directed testbench for bsg_id_pool_multiport_with_reserve
// (els_p=8, alloc_ports_p=2, dealloc_ports_p=2).
//
// Inputs change 1 time unit after each rising edge. Outputs are sampled 1 time
// unit after that, well before the next edge.
// ---------------------------------------------------------------------------
module tb_bsg_id_pool_multiport_with_reserve;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] reserve_i;
  logic [1:0] alloc_v_o;
  logic [5:0] alloc_id_o;
  logic [1:0] alloc_yumi_i;
  logic [1:0] dealloc_v_i;
  logic [5:0] dealloc_id_i;
  logic [3:0] allocated_count_o;
  logic       full_o;

  int checks   = 0;
  int failures = 0;

  bsg_id_pool_multiport_with_reserve
    #(.els_p(8), .alloc_ports_p(2), .dealloc_ports_p(2))
  dut
    (.clk_i            (clk_i)
    ,.reset_i          (reset_i)
    ,.reserve_i        (reserve_i)
    ,.alloc_v_o        (alloc_v_o)
    ,.alloc_id_o       (alloc_id_o)
    ,.alloc_yumi_i     (alloc_yumi_i)
    ,.dealloc_v_i      (dealloc_v_i)
    ,.dealloc_id_i     (dealloc_id_i)
    ,.allocated_count_o(allocated_count_o)
    ,.full_o           (full_o)
    );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    reserve_i    = '0;
    alloc_yumi_i = '0;
    dealloc_v_i  = '0;
    dealloc_id_i = '0;
    tick();
    reset_i = 1'b0;
    #1;
  endtask

  // alloc_id_o = {ch1, ch0}, 3 bits each
  task automatic test_reset();
    reset_i = 1'b1; reserve_i = '0; alloc_yumi_i = '0;
    dealloc_v_i = '0; dealloc_id_i = '0;
    tick(); tick();
    checks++; if (alloc_v_o !== 2'b00) begin failures++; $display("FAIL reset_v got=%b exp=00", alloc_v_o); end
    checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL reset_full got=%b exp=1", full_o); end
    reset_i = 1'b0;
    #1;
    checks++; if (allocated_count_o !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", allocated_count_o); end
    checks++; if (alloc_v_o !== 2'b11) begin failures++; $display("FAIL post_reset_v got=%b exp=11", alloc_v_o); end
    checks++; if (alloc_id_o !== 6'o10) begin failures++; $display("FAIL post_reset_ids got=%o exp=10", alloc_id_o); end
  endtask

  task automatic test_basic_alloc();
    alloc_yumi_i = 2'b11;
    tick();
    alloc_yumi_i = 2'b00;
    #1;
    checks++; if (alloc_id_o !== 6'o32) begin failures++; $display("FAIL basic_ids got=%o exp=32", alloc_id_o); end
    checks++; if (alloc_v_o !== 2'b11) begin failures++; $display("FAIL basic_v got=%b exp=11", alloc_v_o); end
    checks++; if (allocated_count_o !== 4'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", allocated_count_o); end
  endtask

  task automatic test_reserve();
    do_reset();
    reserve_i = 8'b0000_0101;
    #1;
    checks++; if (alloc_id_o !== 6'o31) begin failures++; $display("FAIL reserve_ids got=%o exp=31", alloc_id_o); end
    checks++; if (alloc_v_o !== 2'b11) begin failures++; $display("FAIL reserve_v got=%b exp=11", alloc_v_o); end
    reserve_i = 8'hff;
    #1;
    checks++; if (alloc_v_o !== 2'b00) begin failures++; $display("FAIL reserve_all_v got=%b exp=00", alloc_v_o); end
    checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL reserve_all_full got=%b exp=1", full_o); end
    // Only ID 7 left offerable: one valid channel
    reserve_i = 8'h7f;
    #1;
    checks++; if (alloc_v_o !== 2'b01 || alloc_id_o[2:0] !== 3'd7) begin failures++; $display("FAIL reserve_one v=%b id0=%0d exp v=01 id0=7", alloc_v_o, alloc_id_o[2:0]); end
    reserve_i = '0;
  endtask

  task automatic alloc_all();
    for (int i = 0; i < 4; i++) begin
      alloc_yumi_i = 2'b11;
      tick();
    end
    alloc_yumi_i = 2'b00;
    #1;
  endtask

  task automatic test_full_and_dealloc();
    do_reset();
    alloc_all();
    checks++; if (full_o !== 1'b1 || alloc_v_o !== 2'b00) begin failures++; $display("FAIL full_state full=%b v=%b exp full=1 v=00", full_o, alloc_v_o); end
    checks++; if (allocated_count_o !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", allocated_count_o); end
    dealloc_v_i = 2'b11; dealloc_id_i = {3'd2, 3'd5};
    #1;
    // Returned IDs are not offered in the cycle they are returned
    checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL no_bypass full got=%b exp=1", full_o); end
    tick();
    dealloc_v_i = 2'b00;
    #1;
    checks++; if (alloc_v_o !== 2'b11 || alloc_id_o !== 6'o52) begin failures++; $display("FAIL dealloc_ids v=%b ids=%o exp v=11 ids=52", alloc_v_o, alloc_id_o); end
    checks++; if (allocated_count_o !== 4'd6) begin failures++; $display("FAIL dealloc_count got=%0d exp=6", allocated_count_o); end
  endtask

  task automatic test_simul_alloc_dealloc();
    do_reset();
    alloc_all();
    dealloc_v_i = 2'b11; dealloc_id_i = {3'd1, 3'd0};
    tick();
    dealloc_v_i = 2'b00;
    #1;
    checks++; if (alloc_id_o !== 6'o10 || allocated_count_o !== 4'd6) begin failures++; $display("FAIL simul_setup ids=%o count=%0d exp ids=10 count=6", alloc_id_o, allocated_count_o); end
    alloc_yumi_i = 2'b11;
    dealloc_v_i  = 2'b01; dealloc_id_i = {3'd0, 3'd6};
    #1;
    checks++; if (alloc_id_o !== 6'o10 || alloc_v_o !== 2'b11) begin failures++; $display("FAIL simul_same_cycle ids=%o v=%b exp ids=10 v=11", alloc_id_o, alloc_v_o); end
    tick();
    alloc_yumi_i = 2'b00; dealloc_v_i = 2'b00;
    #1;
    checks++; if (allocated_count_o !== 4'd7) begin failures++; $display("FAIL simul_count got=%0d exp=7", allocated_count_o); end
    checks++; if (alloc_v_o !== 2'b01 || alloc_id_o[2:0] !== 3'd6 || full_o !== 1'b0) begin failures++; $display("FAIL simul_offer v=%b id0=%0d full=%b exp v=01 id0=6 full=0", alloc_v_o, alloc_id_o[2:0], full_o); end
  endtask

  task automatic test_reserve_allocated();
    do_reset();
    alloc_yumi_i = 2'b11; tick();
    alloc_yumi_i = 2'b11; tick();
    alloc_yumi_i = 2'b00;
    reserve_i = 8'b0000_1000;
    #1;
    checks++; if (alloc_id_o !== 6'o54 || allocated_count_o !== 4'd4) begin failures++; $display("FAIL rsv_alloc ids=%o count=%0d exp ids=54 count=4", alloc_id_o, allocated_count_o); end
    dealloc_v_i = 2'b01; dealloc_id_i = {3'd0, 3'd3};
    tick();
    dealloc_v_i = 2'b00;
    #1;
    checks++; if (allocated_count_o !== 4'd3) begin failures++; $display("FAIL rsv_dealloc_count got=%0d exp=3", allocated_count_o); end
    checks++; if (alloc_id_o !== 6'o54) begin failures++; $display("FAIL rsv_not_offered ids=%o exp=54", alloc_id_o); end
    reserve_i = '0;
    #1;
    checks++; if (alloc_id_o !== 6'o43 || alloc_v_o !== 2'b11) begin failures++; $display("FAIL rsv_cleared ids=%o v=%b exp ids=43 v=11", alloc_id_o, alloc_v_o); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    alloc_yumi_i = 2'b11; tick();
    alloc_yumi_i = 2'b11; tick();
    alloc_yumi_i = 2'b01; tick();
    alloc_yumi_i = 2'b00;
    #1;
    checks++; if (allocated_count_o !== 4'd5) begin failures++; $display("FAIL mid_setup_count got=%0d exp=5", allocated_count_o); end
    reset_i = 1'b1; alloc_yumi_i = 2'b11;
    #1;
    checks++; if (alloc_v_o !== 2'b00 || full_o !== 1'b1) begin failures++; $display("FAIL mid_in_reset v=%b full=%b exp v=00 full=1", alloc_v_o, full_o); end
    tick();
    reset_i = 1'b0; alloc_yumi_i = 2'b00;
    #1;
    checks++; if (allocated_count_o !== 4'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", allocated_count_o); end
    checks++; if (alloc_v_o !== 2'b11 || alloc_id_o !== 6'o10) begin failures++; $display("FAIL mid_offer v=%b ids=%o exp v=11 ids=10", alloc_v_o, alloc_id_o); end
  endtask

  initial begin
    test_reset();
    test_basic_alloc();
    test_reserve();
    test_full_and_dealloc();
    test_simul_alloc_dealloc();
    test_reserve_allocated();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
